// File: rtl/muxn_pipe.sv
// N-input, WIDTH-bit registered multiplexer with valid/ready on both sides.
// Define MUXN_PIPE_SKID_EN to add a skid register so that in_ready no longer depends on out_ready.
module muxn_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    err
);

  // A beat is packed as {sel, err, data} so that one register carries everything it needs.
  localparam int BEAT_W = SEL_W + 1 + WIDTH;

  function automatic logic [WIDTH:0] select_input(
    input logic [SEL_W-1:0]        s,
    input logic [NUM_IN*WIDTH-1:0] d
  );
    logic [WIDTH:0] r;
    if (int'(s) < NUM_IN) begin
      r = {1'b0, d[int'(s)*WIDTH +: WIDTH]};
    end else begin
      r = {1'b1, {WIDTH{1'b0}}};
    end
    return r;
  endfunction

  logic [BEAT_W-1:0] in_beat_s;
  logic              accept_s;
  logic              xfer_s;
  logic              in_ready_s;

  logic [BEAT_W-1:0] out_beat_q, out_beat_d;
  logic              out_valid_q, out_valid_d;

  // Beat formed from the current inputs, and the two handshake events.
  always_comb begin
    in_beat_s = {sel, select_input(sel, data_in)};
    accept_s  = in_valid && in_ready_s;
    xfer_s    = out_valid_q && out_ready;
  end

`ifdef MUXN_PIPE_SKID_EN
  logic [BEAT_W-1:0] skid_beat_q, skid_beat_d;
  logic              skid_valid_q, skid_valid_d;

  // in_ready depends only on skid occupancy, which breaks the out_ready path.
  always_comb begin
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !skid_valid_q;
    end
  end

  // Next state: drain the skid first, park a beat that arrives during a stall, otherwise load directly.
  always_comb begin
    out_beat_d   = out_beat_q;
    out_valid_d  = out_valid_q;
    skid_beat_d  = skid_beat_q;
    skid_valid_d = skid_valid_q;
    if (xfer_s && skid_valid_q) begin
      out_beat_d   = skid_beat_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept_s && out_valid_q && !out_ready) begin
      skid_beat_d  = in_beat_s;
      skid_valid_d = 1'b1;
    end else if (accept_s) begin
      out_beat_d  = in_beat_s;
      out_valid_d = 1'b1;
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Skid register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_beat_q  <= {BEAT_W{1'b0}};
      skid_valid_q <= 1'b0;
    end else begin
      skid_beat_q  <= skid_beat_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  // The output register may take a new beat when it is empty or is being emptied this cycle.
  always_comb begin
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !out_valid_q || out_ready;
    end
  end

  // Next state: a new beat replaces the output register even while the old beat is transferring.
  always_comb begin
    out_beat_d  = out_beat_q;
    out_valid_d = out_valid_q;
    if (accept_s) begin
      out_beat_d  = in_beat_s;
      out_valid_d = 1'b1;
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end
`endif

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_beat_q  <= {BEAT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_beat_q  <= out_beat_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Unpack the output register onto the ports.
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = out_valid_q;
    data_out  = out_beat_q[WIDTH-1:0];
    err       = out_beat_q[WIDTH];
    sel_out   = out_beat_q[BEAT_W-1:WIDTH+1];
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench for muxn_pipe: directed steps followed by random traffic,
// checked against a queue-based occupancy model. A NUM_IN=3 instance covers out-of-range select.
module tb_muxn_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // NUM_IN=4 instance
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]   sel, sel_out;
  logic [127:0] data_in;
  logic [31:0]  data_out;

  // NUM_IN=3 instance
  logic         d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_err;
  logic [1:0]   d3_sel, d3_sel_out;
  logic [95:0]  d3_data_in;
  logic [31:0]  d3_data_out;

  muxn_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sel_out(sel_out), .err(err)
  );

  muxn_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .sel(d3_sel), .data_in(d3_data_in), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .data_out(d3_data_out), .sel_out(d3_sel_out), .err(d3_err)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FIXED_IN = {32'hDEADBEEF, 32'h12345678, 32'hFFFF0000, 32'h0000FFFF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of beats the block may hold before it must refuse input.
  function automatic logic exp_ready();
    if (reset) return 1'b0;
`ifdef MUXN_PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  // One clock: check outputs at negedge against the model, then update it at posedge.
  task automatic cycle();
    logic  rdy, acc, xf;
    beat_t b;
    @(negedge clk);
    rdy = exp_ready();
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("data_out", {32'd0, data_out}, {32'd0, q[0].d});
      chk("sel_out", {62'd0, sel_out}, {62'd0, q[0].s});
      chk("err", {63'd0, err}, {63'd0, q[0].e});
    end
    acc = in_valid && rdy;
    xf  = (q.size() > 0) && out_ready;
    b.s = sel;
    b.e = (int'(sel) >= 4);
    b.d = b.e ? 32'd0 : data_in[int'(sel)*32 +: 32];
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; data_in = FIXED_IN;
    d3_in_valid = 1'b0; d3_out_ready = 1'b1; d3_sel = 2'd0; d3_data_in = FIXED_IN[95:0];

    // 1. reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data_out", {32'd0, data_out}, 64'd0);
    chk("rst_sel_out", {62'd0, sel_out}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // 2. back-to-back beats sel=0..3
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // 3. stall after accepting sel=2, with sel=3 pending
    in_valid = 1'b1; sel = 2'd2;
    cycle();
    out_ready = 1'b0; sel = 2'd3;
    for (int k = 0; k < 3; k++) cycle();
    chk("stall_hold", {32'd0, data_out}, {32'd0, 32'h12345678});
    out_ready = 1'b1;
`ifndef MUXN_PIPE_SKID_EN
    cycle();
`endif
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle();

    // 4. out-of-range select on the NUM_IN=3 instance
    #1;
    chk("d3_in_ready", {63'd0, d3_in_ready}, 64'd1);
    d3_in_valid = 1'b1; d3_sel = 2'd3;
    @(posedge clk); #1;
    d3_sel = 2'd1;
    chk("d3_oor_valid", {63'd0, d3_out_valid}, 64'd1);
    chk("d3_oor_data", {32'd0, d3_data_out}, 64'd0);
    chk("d3_oor_err", {63'd0, d3_err}, 64'd1);
    chk("d3_oor_sel", {62'd0, d3_sel_out}, 64'd3);
    @(posedge clk); #1;
    d3_in_valid = 1'b0;
    chk("d3_in_data", {32'd0, d3_data_out}, {32'd0, 32'hFFFF0000});
    chk("d3_in_err", {63'd0, d3_err}, 64'd0);
    chk("d3_in_sel", {62'd0, d3_sel_out}, 64'd1);

    // 5. reset while the output (and skid) is full
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    for (int k = 0; k < 3; k++) cycle();
    reset = 1'b1;
    cycle();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle();

    // 6. random traffic
    for (int k = 0; k < 10000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      data_in   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
